img_stream_reader: RTL and testbench
====================================

# img_stream_reader

Avalon-MM master that reads a contiguous run of 32-bit words from the 1024×32 image buffer RAM and emits them as a backpressured Avalon-ST packet. It connects to one port of the dual-port image RAM: fixed read latency, no waitrequest, chipselect-qualified access. Software or a control FSM fills the RAM through the other port. This block is the consumer on that side.

## Interface
- `READ_LATENCY`, default 1: fixed RAM read latency in cycles. Legal values are 1 or 2.
- `FIFO_DEPTH`, default 4: output buffer depth in words. Must be a power of 2 and ≥ READ_LATENCY+2.
- `clk`, in, 1: single clock for all logic.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: single-cycle request to begin a read run. Sampled only in IDLE.
- `base_addr`, in, 10: first word address, latched on an accepted start.
- `word_count`, in, 11: number of words to read. Legal range 1..1024; values >1024 are clamped to 1024.
- `busy`, out, 1: a run is in progress.
- `done`, out, 1: one-cycle pulse at the end of a run.
- `address`, out, 10: RAM word address.
- `chipselect`, out, 1: RAM access strobe, asserted for reads only.
- `write`, out, 1: tied 0.
- `byteenable`, out, 4: tied 4'hF.
- `clken`, out, 1: tied 1.
- `readdata`, in, 32: RAM read data, valid READ_LATENCY cycles after the chipselect cycle.
- `st_data`, out, 32: stream data.
- `st_valid`, out, 1: stream valid.
- `st_ready`, in, 1: stream ready.
- `st_sop`, out, 1: asserted with the first word of the packet.
- `st_eop`, out, 1: asserted with the last word of the packet.

## Operation
- The FSM has three states: IDLE, ISSUE, DRAIN.
- IDLE → ISSUE on `start` with `word_count` ≠ 0.
  - Latch `base_addr` into `rd_addr`.
  - Latch the clamped count into `remaining` and `total`.
- `start` with `word_count` = 0 in IDLE: no RAM access, no stream beat, `done` pulses the next cycle.
- ISSUE: each cycle where `fifo_count + inflight < FIFO_DEPTH`:
  - Drive `chipselect`=1 with `address`=`rd_addr`.
  - Increment `rd_addr` modulo 1024; it wraps 1023 → 0 silently.
  - Decrement `remaining`.
  - When the last read is issued, go to DRAIN.
- `inflight` tracks issued reads whose data has not yet returned. It is a shift register of READ_LATENCY valid bits.
- Returned `readdata` is written to the FIFO in the cycle it is valid. Credit accounting guarantees the FIFO never overflows.
- DRAIN: wait until `inflight`=0, the FIFO is empty, and the eop beat has been handshaken. Then pulse `done` and return to IDLE.
- Stream rules:
  - The FIFO head drives `st_data` and `st_valid`.
  - A beat transfers when `st_valid & st_ready`.
  - `st_sop` is asserted on the beat with index 0.
  - `st_eop` is asserted on the beat with index `total`-1. A one-word run has sop and eop on the same beat.
  - Held data, sop and eop are stable while `st_valid` is high and `st_ready` is low.
- `start` while busy is ignored. No queuing, no effect on the run in progress.
- Reset mid-run:
  - State → IDLE.
  - FIFO flushed, `inflight` cleared.
  - RAM data arriving after reset is discarded.
- Reset values:
  - `busy`=0, `done`=0, `chipselect`=0, `address`=0.
  - `st_valid`=0, `st_sop`=0, `st_eop`=0, `st_data`=0.

## Timing
- `start` high in cycle n (IDLE): `busy` and `chipselect` go high in cycle n+1, with `address`=`base_addr`.
- With `st_ready` held high, first `st_valid` is in cycle n+2+READ_LATENCY.
- Throughput is one word per cycle with no bubbles when `st_ready`=1 and FIFO_DEPTH ≥ READ_LATENCY+2.
- Backpressure: once `st_ready` drops, `chipselect` stops within 1 cycle once credit is exhausted. It resumes the cycle after a beat frees credit.
- `busy` remains high through the eop handshake cycle. It is low and `done`=1 in the following cycle.
- `done` is high for exactly one cycle.
- All outputs are registered. No combinational path from `st_ready` to `chipselect` except through the credit compare.

## Test plan
- **Basic run:** `base_addr`=0x010, `word_count`=8, RAM[i]=i, `st_ready`=1 → `chipselect` for 8 consecutive cycles at 0x010..0x017; stream 0x10..0x17; sop on the first beat, eop on the 8th; `done` exactly once; first `st_valid` at n+3.
- **Wrap:** `base_addr`=0x3FE, `word_count`=4 → addresses 0x3FE, 0x3FF, 0x000, 0x001 in order; data matches.
- **Backpressure:** `word_count`=16, `st_ready` random 30% duty → all 16 words delivered in order with no loss or duplication; `fifo_count+inflight` never exceeds 4; sop/eop/data stable while stalled.
- **Edge counts:**
  - `word_count`=1 → a single beat with sop=eop=1.
  - `word_count`=0 → no `chipselect`, no beats, `done` at n+1.
  - `word_count`=1500 → exactly 1024 beats.
- **Start while busy:** second `start` during a run → ignored; exactly one packet and one `done`.
- **Reset mid-run:** assert `reset` during the 5th beat of a 16-word run → all outputs at reset values immediately. A new run after reset delivers a clean packet with sop on its first beat.

Source files
------------

// File: rtl/img_stream_reader.sv
// img_stream_reader: reads a contiguous run of words from the image RAM
// and replays them as one backpressured Avalon-ST packet.
module img_stream_reader #(
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [9:0]  base_addr,
    input  logic [10:0] word_count,
    output logic        busy,
    output logic        done,
    output logic [9:0]  address,
    output logic        chipselect,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic        clken,
    input  logic [31:0] readdata,
    output logic [31:0] st_data,
    output logic        st_valid,
    input  logic        st_ready,
    output logic        st_sop,
    output logic        st_eop
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = AW + 3;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                  r_state;
    logic [9:0]              r_rd_addr;
    logic [10:0]             r_remaining;
    logic [10:0]             r_total;
    logic [10:0]             r_beat;
    logic [READ_LATENCY-1:0] r_infl;
    logic [31:0]             r_mem [FIFO_DEPTH];
    logic [AW-1:0]           r_wptr;
    logic [AW-1:0]           r_rptr;
    logic [CW-1:0]           r_count;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_cs;
    logic [9:0]              r_address;
    logic                    r_st_valid;
    logic                    r_st_sop;
    logic                    r_st_eop;
    logic [31:0]             r_st_data;

    logic [10:0]             w_clamp;
    logic                    w_pop;
    logic                    w_push;
    logic [CW-1:0]           w_left;
    logic [CW-1:0]           w_count_nxt;
    logic [AW-1:0]           w_rptr_nxt;
    logic [31:0]             w_head;
    logic [10:0]             w_beat_nxt;
    logic [OW-1:0]           w_infl_cnt;
    logic [OW-1:0]           w_occ;
    logic                    w_credit;
    logic [READ_LATENCY-1:0] w_infl_shift;

    always_comb begin
        w_clamp     = (word_count > 11'd1024) ? 11'd1024 : word_count;
        w_pop       = r_st_valid & st_ready;
        w_push      = r_infl[READ_LATENCY-1];
        w_left      = r_count - CW'(w_pop);
        w_count_nxt = w_left + CW'(w_push);
        w_rptr_nxt  = r_rptr + AW'(w_pop);
        // An empty FIFO forwards the returning word straight to the head.
        w_head      = (w_left == '0) ? readdata : r_mem[w_rptr_nxt];
        w_beat_nxt  = r_beat + 11'(w_pop);
        w_infl_cnt  = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_infl_cnt = w_infl_cnt + OW'(r_infl[i]);
        end
        // Words held or owed after this cycle, including this cycle's read.
        w_occ        = OW'(w_left) + w_infl_cnt + OW'(r_cs);
        w_credit     = w_occ < OW'(FIFO_DEPTH);
        w_infl_shift = r_infl << 1;
        w_infl_shift[0] = r_cs;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= readdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rd_addr   <= '0;
            r_remaining <= '0;
            r_total     <= '0;
            r_beat      <= '0;
            r_infl      <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cs        <= 1'b0;
            r_address   <= '0;
            r_st_valid  <= 1'b0;
            r_st_sop    <= 1'b0;
            r_st_eop    <= 1'b0;
            r_st_data   <= '0;
        end else begin
            r_done     <= 1'b0;
            r_cs       <= 1'b0;
            r_infl     <= w_infl_shift;
            r_wptr     <= r_wptr + AW'(w_push);
            r_rptr     <= w_rptr_nxt;
            r_count    <= w_count_nxt;
            r_beat     <= w_beat_nxt;
            r_st_valid <= (w_count_nxt != '0);
            r_st_sop   <= 1'b0;
            r_st_eop   <= 1'b0;
            if (w_count_nxt != '0) begin
                r_st_data <= w_head;
                r_st_sop  <= (w_beat_nxt == 11'd0);
                r_st_eop  <= (w_beat_nxt == r_total - 11'd1);
            end
            unique case (r_state)
                IDLE: begin
                    if (start && w_clamp != 11'd0) begin
                        r_cs        <= 1'b1;
                        r_address   <= base_addr;
                        r_rd_addr   <= base_addr + 10'd1;
                        r_remaining <= w_clamp - 11'd1;
                        r_total     <= w_clamp;
                        r_beat      <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= (w_clamp == 11'd1) ? DRAIN : ISSUE;
                    end else if (start) begin
                        r_done <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (w_credit) begin
                        r_cs        <= 1'b1;
                        r_address   <= r_rd_addr;
                        r_rd_addr   <= r_rd_addr + 10'd1;
                        r_remaining <= r_remaining - 11'd1;
                        if (r_remaining == 11'd1) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_pop && r_st_eop) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign address    = r_address;
    assign chipselect = r_cs;
    assign write      = 1'b0;
    assign byteenable = 4'hF;
    assign clken      = 1'b1;
    assign st_data    = r_st_data;
    assign st_valid   = r_st_valid;
    assign st_sop     = r_st_sop;
    assign st_eop     = r_st_eop;

endmodule

// File: tb/tb_img_stream_reader.sv
// tb_img_stream_reader: table-driven and randomized packet runs against
// a queue-based model of the expected address and data streams.
module tb_img_stream_reader;
    localparam int RL = 1;
    localparam int FD = 4;

    logic        clk;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] word_count;
    logic        busy;
    logic        done;
    logic [9:0]  address;
    logic        chipselect;
    logic        write;
    logic [3:0]  byteenable;
    logic        clken;
    logic [31:0] readdata;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_ready;
    logic        st_sop;
    logic        st_eop;

    img_stream_reader #(.READ_LATENCY(RL), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .start(start),
        .base_addr(base_addr), .word_count(word_count),
        .busy(busy), .done(done), .address(address),
        .chipselect(chipselect), .write(write),
        .byteenable(byteenable), .clken(clken),
        .readdata(readdata), .st_data(st_data),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_sop(st_sop), .st_eop(st_eop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int duty = 100;
    initial begin
        st_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            st_ready = ($urandom_range(0, 99) < duty);
        end
    end

    logic [31:0] ram [1024];
    logic [31:0] rd_pipe [RL];
    always @(posedge clk) begin
        rd_pipe[0] <= chipselect ? ram[address] : (32'hDEAD0000 | 32'(cyc[15:0]));
        for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign readdata = rd_pipe[RL-1];

    int n_checks = 0;
    int n_fail = 0;

    logic [9:0]  got_a[$];
    logic [31:0] got_d[$];
    bit          got_s[$];
    bit          got_e[$];
    int issued, accepted, occ_viol, stab_viol;
    int first_cs, first_valid, done_cnt, done_cyc, last_beat;
    bit prev_stall;
    logic [31:0] pd;
    logic ps, pe;

    typedef struct {
        logic [9:0]  base;
        logic [10:0] wc;
        int          duty;
        bit          poke;
        int          beats;
        logic [9:0]  last;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cs"}, chipselect, 0);
        chk({tag, "_addr"}, address, 0);
        chk({tag, "_valid"}, st_valid, 0);
        chk({tag, "_sop"}, st_sop, 0);
        chk({tag, "_eop"}, st_eop, 0);
        chk({tag, "_data"}, st_data, 0);
    endtask

    task automatic clear_mon();
        got_a.delete(); got_d.delete(); got_s.delete(); got_e.delete();
        issued = 0; accepted = 0; occ_viol = 0; stab_viol = 0;
        first_cs = -1; first_valid = -1; done_cnt = 0;
        done_cyc = -1; last_beat = -1; prev_stall = 0;
    endtask

    task automatic step();
        @(negedge clk);
        if (chipselect) begin
            got_a.push_back(address);
            issued++;
            if (first_cs < 0) first_cs = cyc;
        end
        if (issued - accepted > FD) occ_viol++;
        if (st_valid && first_valid < 0) first_valid = cyc;
        if (prev_stall && (!st_valid || st_data !== pd || st_sop !== ps || st_eop !== pe))
            stab_viol++;
        if (st_valid && st_ready) begin
            got_d.push_back(st_data);
            got_s.push_back(st_sop);
            got_e.push_back(st_eop);
            accepted++;
            last_beat = cyc;
        end
        prev_stall = st_valid && !st_ready;
        pd = st_data; ps = st_sop; pe = st_eop;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic run_pkt(input logic [9:0] b, input logic [10:0] wc, input int dy,
                           input bit poke, input int xbeats, input logic [9:0] xlast);
        int n, t0, nsop, neop, dd, da;
        logic [31:0] xd[$];
        logic [9:0]  xa[$];
        n = (wc > 11'd1024) ? 1024 : int'(wc);
        for (int i = 0; i < n; i++) begin
            xa.push_back(10'((int'(b) + i) % 1024));
            xd.push_back(ram[(int'(b) + i) % 1024]);
        end
        clear_mon();
        duty = dy;
        start = 1'b1; base_addr = b; word_count = wc; t0 = cyc;
        step();
        start = 1'b0; base_addr = 10'($urandom); word_count = 11'($urandom);
        chk("busy_rise", busy, 1);
        chk("cs_rise", chipselect, 1);
        chk("addr_first", address, b);
        for (int k = 0; k < 6 * n + 100 && done_cnt == 0; k++) begin
            if (poke && k == 2) begin
                start = 1'b1; base_addr = b ^ 10'h155; word_count = 11'd3;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        chk("done_seen", done_cnt, 1);
        repeat (6) step();
        chk("done_once", done_cnt, 1);
        chk("busy_end", busy, 0);
        chk("beats_tbl", got_d.size(), xbeats);
        chk("beats_model", got_d.size(), n);
        chk("reads", got_a.size(), n);
        dd = 0; da = 0; nsop = 0; neop = 0;
        for (int i = 0; i < got_d.size() && i < n; i++) begin
            if (got_d[i] !== xd[i]) dd++;
            nsop += int'(got_s[i]);
            neop += int'(got_e[i]);
        end
        for (int i = 0; i < got_a.size() && i < n; i++)
            if (got_a[i] !== xa[i]) da++;
        chk("data_mismatches", dd, 0);
        chk("addr_mismatches", da, 0);
        if (got_a.size() > 0) chk("last_addr", got_a[$], xlast);
        chk("sop_count", nsop, 1);
        chk("eop_count", neop, 1);
        if (got_s.size() > 0) chk("sop_first", got_s[0], 1);
        if (got_e.size() > 0) chk("eop_last", got_e[$], 1);
        chk("first_cs_cyc", first_cs, t0 + 1);
        chk("first_valid_cyc", first_valid, t0 + 2 + RL);
        chk("done_after_eop", done_cyc, last_beat + 1);
        chk("occupancy", occ_viol, 0);
        chk("stall_hold", stab_viol, 0);
    endtask

    initial begin
        int t0;
        tbl[0] = '{10'h010, 11'd8,    100, 1'b0, 8,    10'h017};
        tbl[1] = '{10'h3FE, 11'd4,    100, 1'b0, 4,    10'h001};
        tbl[2] = '{10'h100, 11'd16,   30,  1'b0, 16,   10'h10F};
        tbl[3] = '{10'h020, 11'd1,    100, 1'b0, 1,    10'h020};
        tbl[4] = '{10'h200, 11'd1500, 100, 1'b0, 1024, 10'h1FF};
        tbl[5] = '{10'h0C0, 11'd16,   100, 1'b1, 16,   10'h0CF};
        tbl[6] = '{10'h3F0, 11'd1024, 70,  1'b0, 1024, 10'h3EF};
        tbl[7] = '{10'h055, 11'd32,   50,  1'b0, 32,   10'h074};
        for (int i = 0; i < 1024; i++) ram[i] = 32'(i);
        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        clear_mon();
        repeat (3) @(negedge clk);
        chk_rst("por");
        chk("write_tie", write, 0);
        chk("be_tie", byteenable, 4'hF);
        chk("clken_tie", clken, 1);
        reset = 1'b0;
        step(); step();

        for (int v = 0; v < 8; v++)
            run_pkt(tbl[v].base, tbl[v].wc, tbl[v].duty, tbl[v].poke,
                    tbl[v].beats, tbl[v].last);

        for (int i = 0; i < 1024; i++) ram[i] = $urandom;
        for (int r = 0; r < 6; r++) begin
            logic [9:0] b;
            int wc;
            b = 10'($urandom);
            wc = $urandom_range(1, 40);
            run_pkt(b, 11'(wc), $urandom_range(20, 100), 1'b0, wc, 10'(int'(b) + wc - 1));
        end

        clear_mon();
        start = 1'b1; word_count = 11'd0; base_addr = 10'h123; t0 = cyc;
        step();
        start = 1'b0;
        chk("zero_done_cyc", done_cyc, t0 + 1);
        chk("zero_busy", busy, 0);
        repeat (5) step();
        chk("zero_done_once", done_cnt, 1);
        chk("zero_reads", got_a.size(), 0);
        chk("zero_beats", got_d.size(), 0);

        clear_mon();
        duty = 100;
        start = 1'b1; base_addr = 10'h080; word_count = 11'd16;
        step();
        start = 1'b0;
        for (int k = 0; k < 60 && accepted < 5; k++) step();
        chk("rst_reach_beat5", accepted, 5);
        reset = 1'b1;
        #1;
        chk_rst("midrun");
        step(); step();
        reset = 1'b0;
        chk("rst_no_done", done_cnt, 0);
        step();
        run_pkt(10'h300, 11'd10, 100, 1'b0, 10, 10'h309);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
